// File: rtl/dmem_responder_if.sv
// Data-memory bus between the M-stage datapath (master) and
// the data-memory responder (slave).
interface dmem_responder_if;
    logic        MemReadM;
    logic        MemWriteM;
    logic        ByteM;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallMem;
    logic        AlignErrM;

    modport master (
        output MemReadM, MemWriteM, ByteM, AddrM, WriteDataM,
        input  ReadDataM, StallMem, AlignErrM
    );

    modport slave (
        input  MemReadM, MemWriteM, ByteM, AddrM, WriteDataM,
        output ReadDataM, StallMem, AlignErrM
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory for the M stage; stalls the pipe per access.
// Byte lanes (LDRB/STRB) are built only with DMEM_BYTE_ACCESS_EN defined.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  dmem
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [31:0]   mem [DEPTH];

    logic          req;
    logic          we;
    logic          stall;
    logic          misalign;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   wword;
    logic [31:0]   rword;

    assign req  = dmem.MemReadM | dmem.MemWriteM;
    assign idx  = dmem.AddrM[AW+1:2];
    assign lane = dmem.AddrM[1:0];

`ifdef DMEM_BYTE_ACCESS_EN
    always_comb begin
        wword = dmem.WriteDataM;
        rword = mem[idx];
        if (dmem.ByteM) begin
            wword = mem[idx];
            wword[{lane, 3'b000} +: 8] = dmem.WriteDataM[7:0];
            rword = {24'h0, mem[idx][{lane, 3'b000} +: 8]};
        end
    end
    assign misalign = !dmem.ByteM && (lane != 2'b00);
    logic unused_hi;
    assign unused_hi = ^dmem.AddrM[31:AW+2];
`else
    assign wword    = dmem.WriteDataM;
    assign rword    = mem[idx];
    assign misalign = (lane != 2'b00);
    logic unused_hi;
    assign unused_hi = ^{dmem.AddrM[31:AW+2], dmem.ByteM};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem[idx] <= wword;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        stall   = 1'b0;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = req;
                if (req) begin
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = DONE;
                    err_d   = misalign && req;
                    if (dmem.MemWriteM) begin
                        we = 1'b1;
                    end else if (dmem.MemReadM) begin
                        rdata_d = rword;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dmem.ReadDataM = rdata_q;
    assign dmem.StallMem  = stall;
    assign dmem.AlignErrM = err_q;
endmodule
